// File: rtl/pipe_trace_buffer.sv
// pipe_trace_buffer: ring buffer of {seq, pc, instr} retire records with trigger freeze and valid/ready drain
module pipe_trace_buffer #(
  parameter int XLEN     = 32,
  parameter int DEPTH    = 16,
  parameter int AW       = 4,
  parameter int SEQ_W    = 16,
  parameter bit WRAP     = 1'b1,
  parameter int POST_CNT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             cap_en,
  input  logic             cap_valid,
  input  logic [XLEN-1:0]  cap_pc,
  input  logic [31:0]      cap_instr,
  input  logic             trig,
  input  logic             rd_ready,
  output logic             rd_valid,
  output logic [SEQ_W-1:0] rd_seq,
  output logic [XLEN-1:0]  rd_pc,
  output logic [31:0]      rd_instr,
  output logic [AW:0]      count,
  output logic             overflow,
  output logic             frozen
);
  typedef enum logic [1:0] {ARMED, POST, FROZEN} state_t;
  localparam logic [AW:0] FULL      = (AW+1)'(DEPTH);
  localparam logic [AW:0] POST_INIT = (AW+1)'(POST_CNT);
  state_t             state_q, state_d;
  logic [AW-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]        count_q, count_d, post_q, post_d;
  logic [SEQ_W-1:0]   seq_q, seq_d;
  logic               ovf_q, ovf_d, frozen_q, frozen_d;
  logic               offer, trig0, take, full, pop, we;
  logic [SEQ_W+XLEN+31:0] mem [DEPTH];
  assign offer    = cap_en & cap_valid & (state_q != FROZEN);
  // a trigger with no post window freezes immediately and swallows the same-cycle offer
  assign trig0    = (state_q == ARMED) & trig & (POST_INIT == '0);
  assign take     = offer & ~trig0;
  assign full     = count_q == FULL;
  assign rd_valid = count_q != '0;
  assign pop      = rd_valid & rd_ready;
  assign we       = take & (~full | WRAP | pop);
  assign count    = count_q;
  assign overflow = ovf_q;
  assign frozen   = frozen_q;
  assign {rd_seq, rd_pc, rd_instr} = rd_valid ? mem[rd_ptr_q] : '0;
  // next-state for pointers, occupancy, sequence, overflow and trigger FSM
  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    post_d   = post_q;
    seq_d    = seq_q;
    ovf_d    = ovf_q;
    if (clear) begin
      state_d  = ARMED;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      post_d   = '0;
      seq_d    = '0;
      ovf_d    = 1'b0;
    end else begin
      seq_d    = take ? seq_q + 1'b1 : seq_q;
      wr_ptr_d = we ? wr_ptr_q + 1'b1 : wr_ptr_q;
      rd_ptr_d = (pop | (take & full & WRAP)) ? rd_ptr_q + 1'b1 : rd_ptr_q;
      count_d  = (we & ~full & ~pop) ? count_q + 1'b1 : (~we & pop) ? count_q - 1'b1 : count_q;
      ovf_d    = ovf_q | (take & full & (WRAP | ~pop));
      if (state_q == ARMED && trig) begin
        state_d = trig0 ? FROZEN : POST;
        post_d  = POST_INIT;
      end else if (state_q == POST && take) begin
        post_d  = post_q - 1'b1;
        state_d = (post_q == (AW+1)'(1)) ? FROZEN : POST;
      end
    end
  end
  assign frozen_d = state_d == FROZEN;
  // control state with asynchronous reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ARMED;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      post_q   <= '0;
      seq_q    <= '0;
      ovf_q    <= 1'b0;
      frozen_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      post_q   <= post_d;
      seq_q    <= seq_d;
      ovf_q    <= ovf_d;
      frozen_q <= frozen_d;
    end
  end
  // trace storage, not reset; validity is tracked by count
  always_ff @(posedge clk) begin
    if (we && !clear) mem[wr_ptr_q] <= {seq_q, cap_pc, cap_instr};
  end
endmodule

// File: tb/tb_pipe_trace_buffer.sv
// tb_pipe_trace_buffer: directed checks on wrap, stop-on-full and zero-post-window instances
module tb_pipe_trace_buffer;
  logic clk = 1'b0, rst = 1'b1, clear = 1'b0, cap_en = 1'b0, cap_valid = 1'b0, trig = 1'b0, rd_ready = 1'b0;
  logic [31:0] cap_pc = '0, cap_instr = '0;
  logic a_rd_valid, a_overflow, a_frozen, b_rd_valid, b_overflow, b_frozen, c_rd_valid, c_overflow, c_frozen;
  logic [15:0] a_rd_seq, b_rd_seq, c_rd_seq;
  logic [31:0] a_rd_pc, a_rd_instr, b_rd_pc, b_rd_instr, c_rd_pc, c_rd_instr;
  logic [4:0] a_count, b_count, c_count;
  int checks = 0, failures = 0;
  always #5 clk = ~clk;
  pipe_trace_buffer #(.WRAP(1'b1), .POST_CNT(4)) u_a (.clk(clk), .rst(rst), .clear(clear), .cap_en(cap_en),
    .cap_valid(cap_valid), .cap_pc(cap_pc), .cap_instr(cap_instr), .trig(trig), .rd_ready(rd_ready),
    .rd_valid(a_rd_valid), .rd_seq(a_rd_seq), .rd_pc(a_rd_pc), .rd_instr(a_rd_instr), .count(a_count),
    .overflow(a_overflow), .frozen(a_frozen));
  pipe_trace_buffer #(.WRAP(1'b0), .POST_CNT(4)) u_b (.clk(clk), .rst(rst), .clear(clear), .cap_en(cap_en),
    .cap_valid(cap_valid), .cap_pc(cap_pc), .cap_instr(cap_instr), .trig(trig), .rd_ready(rd_ready),
    .rd_valid(b_rd_valid), .rd_seq(b_rd_seq), .rd_pc(b_rd_pc), .rd_instr(b_rd_instr), .count(b_count),
    .overflow(b_overflow), .frozen(b_frozen));
  pipe_trace_buffer #(.WRAP(1'b1), .POST_CNT(0)) u_c (.clk(clk), .rst(rst), .clear(clear), .cap_en(cap_en),
    .cap_valid(cap_valid), .cap_pc(cap_pc), .cap_instr(cap_instr), .trig(trig), .rd_ready(rd_ready),
    .rd_valid(c_rd_valid), .rd_seq(c_rd_seq), .rd_pc(c_rd_pc), .rd_instr(c_rd_instr), .count(c_count),
    .overflow(c_overflow), .frozen(c_frozen));
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic offer(input logic [31:0] pc);
    cap_valid = 1'b1;
    cap_pc = pc;
    cap_instr = 32'h13 + pc;
    tick();
    cap_valid = 1'b0;
  endtask
  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask
  task automatic test_reset();
    rst = 1'b1;
    cap_en = 1'b1;
    tick();
    checks += 5;
    if (a_count !== 5'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", a_count); end
    if (a_rd_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", a_rd_valid); end
    if (a_overflow !== 1'b0) begin failures++; $display("FAIL reset_ovf got=%b exp=0", a_overflow); end
    if (a_frozen !== 1'b0) begin failures++; $display("FAIL reset_frozen got=%b exp=0", a_frozen); end
    if (a_rd_seq !== 16'd0) begin failures++; $display("FAIL reset_seq got=%0d exp=0", a_rd_seq); end
    rst = 1'b0;
    tick();
  endtask
  task automatic test_basic();
    offer(32'h0);
    offer(32'h4);
    offer(32'h8);
    checks += 5;
    if (a_count !== 5'd3) begin failures++; $display("FAIL basic_count got=%0d exp=3", a_count); end
    if (a_rd_valid !== 1'b1) begin failures++; $display("FAIL basic_valid got=%b exp=1", a_rd_valid); end
    if (a_rd_seq !== 16'd0) begin failures++; $display("FAIL basic_seq got=%0d exp=0", a_rd_seq); end
    if (a_rd_pc !== 32'h0) begin failures++; $display("FAIL basic_pc got=%h exp=0", a_rd_pc); end
    if (a_rd_instr !== 32'h13) begin failures++; $display("FAIL basic_instr got=%h exp=13", a_rd_instr); end
    rd_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      checks += 2;
      if (a_rd_seq !== 16'(i)) begin failures++; $display("FAIL drain_seq%0d got=%0d exp=%0d", i, a_rd_seq, i); end
      if (a_rd_pc !== 32'(4*i)) begin failures++; $display("FAIL drain_pc%0d got=%h exp=%h", i, a_rd_pc, 4*i); end
      tick();
    end
    rd_ready = 1'b0;
    checks += 4;
    if (a_count !== 5'd0) begin failures++; $display("FAIL drain_count got=%0d exp=0", a_count); end
    if (a_rd_valid !== 1'b0) begin failures++; $display("FAIL drain_valid got=%b exp=0", a_rd_valid); end
    if (a_rd_pc !== 32'h0) begin failures++; $display("FAIL empty_pc got=%h exp=0", a_rd_pc); end
    if (a_rd_instr !== 32'h0) begin failures++; $display("FAIL empty_instr got=%h exp=0", a_rd_instr); end
  endtask
  task automatic test_full();
    do_clear();
    for (int i = 0; i < 20; i++) offer(32'(4*i));
    checks += 7;
    if (a_count !== 5'd16) begin failures++; $display("FAIL wrap_count got=%0d exp=16", a_count); end
    if (a_overflow !== 1'b1) begin failures++; $display("FAIL wrap_ovf got=%b exp=1", a_overflow); end
    if (a_rd_seq !== 16'd4) begin failures++; $display("FAIL wrap_seq got=%0d exp=4", a_rd_seq); end
    if (a_rd_pc !== 32'h10) begin failures++; $display("FAIL wrap_pc got=%h exp=10", a_rd_pc); end
    if (b_count !== 5'd16) begin failures++; $display("FAIL stop_count got=%0d exp=16", b_count); end
    if (b_overflow !== 1'b1) begin failures++; $display("FAIL stop_ovf got=%b exp=1", b_overflow); end
    if (b_rd_seq !== 16'd0) begin failures++; $display("FAIL stop_seq got=%0d exp=0", b_rd_seq); end
    cap_valid = 1'b1;
    cap_pc = 32'h50;
    rd_ready = 1'b1;
    tick();
    cap_valid = 1'b0;
    checks += 3;
    if (b_count !== 5'd16) begin failures++; $display("FAIL stop_pop_count got=%0d exp=16", b_count); end
    if (b_rd_seq !== 16'd1) begin failures++; $display("FAIL stop_pop_seq got=%0d exp=1", b_rd_seq); end
    if (a_count !== 5'd16) begin failures++; $display("FAIL wrap_pop_count got=%0d exp=16", a_count); end
    repeat (14) tick();
    checks += 1;
    if (b_rd_seq !== 16'd15) begin failures++; $display("FAIL stop_last_seq got=%0d exp=15", b_rd_seq); end
    tick();
    rd_ready = 1'b0;
    checks += 3;
    if (b_rd_seq !== 16'd20) begin failures++; $display("FAIL stop_new_seq got=%0d exp=20", b_rd_seq); end
    if (b_rd_pc !== 32'h50) begin failures++; $display("FAIL stop_new_pc got=%h exp=50", b_rd_pc); end
    if (b_count !== 5'd1) begin failures++; $display("FAIL stop_end_count got=%0d exp=1", b_count); end
  endtask
  task automatic test_post();
    do_clear();
    for (int i = 0; i < 5; i++) offer(32'(4*i));
    trig = 1'b1;
    offer(32'h14);
    trig = 1'b0;
    checks += 4;
    if (a_frozen !== 1'b0) begin failures++; $display("FAIL post_trig_frozen got=%b exp=0", a_frozen); end
    if (a_count !== 5'd6) begin failures++; $display("FAIL post_trig_count got=%0d exp=6", a_count); end
    if (c_frozen !== 1'b1) begin failures++; $display("FAIL p0_frozen got=%b exp=1", c_frozen); end
    if (c_count !== 5'd5) begin failures++; $display("FAIL p0_count got=%0d exp=5", c_count); end
    for (int i = 6; i < 9; i++) offer(32'(4*i));
    checks += 1;
    if (a_frozen !== 1'b0) begin failures++; $display("FAIL post_early_frozen got=%b exp=0", a_frozen); end
    offer(32'h24);
    checks += 2;
    if (a_frozen !== 1'b1) begin failures++; $display("FAIL post_frozen got=%b exp=1", a_frozen); end
    if (a_count !== 5'd10) begin failures++; $display("FAIL post_count got=%0d exp=10", a_count); end
    offer(32'h28);
    offer(32'h2c);
    checks += 1;
    if (a_count !== 5'd10) begin failures++; $display("FAIL frozen_count got=%0d exp=10", a_count); end
    rd_ready = 1'b1;
    repeat (5) tick();
    checks += 2;
    if (a_rd_seq !== 16'd5) begin failures++; $display("FAIL trig_entry_seq got=%0d exp=5", a_rd_seq); end
    if (a_rd_pc !== 32'h14) begin failures++; $display("FAIL trig_entry_pc got=%h exp=14", a_rd_pc); end
    repeat (4) tick();
    checks += 2;
    if (a_rd_seq !== 16'd9) begin failures++; $display("FAIL last_entry_seq got=%0d exp=9", a_rd_seq); end
    if (a_rd_pc !== 32'h24) begin failures++; $display("FAIL last_entry_pc got=%h exp=24", a_rd_pc); end
    tick();
    rd_ready = 1'b0;
    checks += 2;
    if (a_count !== 5'd0) begin failures++; $display("FAIL frozen_drain_count got=%0d exp=0", a_count); end
    if (a_frozen !== 1'b1) begin failures++; $display("FAIL frozen_hold got=%b exp=1", a_frozen); end
    do_clear();
    checks += 3;
    if (a_frozen !== 1'b0) begin failures++; $display("FAIL clear_frozen got=%b exp=0", a_frozen); end
    if (a_count !== 5'd0) begin failures++; $display("FAIL clear_count got=%0d exp=0", a_count); end
    if (c_frozen !== 1'b0) begin failures++; $display("FAIL clear_p0_frozen got=%b exp=0", c_frozen); end
  endtask
  task automatic test_post0();
    do_clear();
    offer(32'h40);
    trig = 1'b1;
    offer(32'h44);
    trig = 1'b0;
    checks += 3;
    if (c_count !== 5'd1) begin failures++; $display("FAIL p0_nostore_count got=%0d exp=1", c_count); end
    if (c_frozen !== 1'b1) begin failures++; $display("FAIL p0_next_frozen got=%b exp=1", c_frozen); end
    if (c_rd_pc !== 32'h40) begin failures++; $display("FAIL p0_head_pc got=%h exp=40", c_rd_pc); end
  endtask
  task automatic test_async_rst();
    do_clear();
    for (int i = 0; i < 3; i++) offer(32'(4*i));
    trig = 1'b1;
    offer(32'hc);
    trig = 1'b0;
    for (int i = 4; i < 7; i++) offer(32'(4*i));
    checks += 2;
    if (a_count !== 5'd7) begin failures++; $display("FAIL pre_rst_count got=%0d exp=7", a_count); end
    if (a_frozen !== 1'b0) begin failures++; $display("FAIL pre_rst_frozen got=%b exp=0", a_frozen); end
    #2 rst = 1'b1;
    #1;
    checks += 5;
    if (a_count !== 5'd0) begin failures++; $display("FAIL arst_count got=%0d exp=0", a_count); end
    if (a_rd_valid !== 1'b0) begin failures++; $display("FAIL arst_valid got=%b exp=0", a_rd_valid); end
    if (a_rd_pc !== 32'h0) begin failures++; $display("FAIL arst_pc got=%h exp=0", a_rd_pc); end
    if (a_rd_instr !== 32'h0) begin failures++; $display("FAIL arst_instr got=%h exp=0", a_rd_instr); end
    if (c_frozen !== 1'b0) begin failures++; $display("FAIL arst_p0_frozen got=%b exp=0", c_frozen); end
    rst = 1'b0;
    offer(32'h100);
    checks += 2;
    if (a_rd_seq !== 16'd0) begin failures++; $display("FAIL post_rst_seq got=%0d exp=0", a_rd_seq); end
    if (a_count !== 5'd1) begin failures++; $display("FAIL post_rst_count got=%0d exp=1", a_count); end
  endtask
  initial begin
    test_reset();
    test_basic();
    test_full();
    test_post();
    test_post0();
    test_async_rst();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
